temperature_sensor_responder: RTL and testbench



---
 rtl/temperature_sensor_responder.sv | 153 +++++++++++++++
 tb/tb_temperature_sensor_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/temperature_sensor_responder.sv
// temperature_sensor_responder: I2C read-only target returning a 16-bit temperature word.
// Answers DEVICE_ADDRESS/R with MSB then LSB, alternating while the master keeps ACKing.
module temperature_sensor_responder #(
    parameter logic [6:0] DEVICE_ADDRESS = 7'h4B
) (
    input  logic        clk_200KHz,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    input  logic [15:0] temperature_word,
    output logic        sda_pull_low,
    output logic        busy,
    output logic        address_hit,
    output logic        read_done
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, TX_BYTE, MASTER_ACK, WAIT_STOP} state_t;
    state_t state, state_nxt;
    logic [1:0] scl_sync, sda_sync;
    logic scl_hist, sda_hist, scl, sda;
    logic scl_rise, scl_fall, start, stop;
    logic [7:0] rx_sr, rx_sr_nxt, tx_sr, tx_sr_nxt, cur_byte;
    logic [3:0] bit_cnt, bit_cnt_nxt;
    logic byte_sel, byte_sel_nxt;
    logic [15:0] tx_shadow, tx_shadow_nxt;
    logic pull_nxt, busy_nxt, hit_nxt, done_nxt;

    assign scl      = scl_sync[1];
    assign sda      = sda_sync[1];
    assign scl_rise = scl & ~scl_hist;
    assign scl_fall = ~scl & scl_hist;
    assign start    = scl & scl_hist & sda_hist & ~sda;
    assign stop     = scl & scl_hist & ~sda_hist & sda;
    assign cur_byte = byte_sel ? tx_shadow[7:0] : tx_shadow[15:8];

    // Synchronizers reset to the idle-bus level so release of reset creates no edges
    always_ff @(posedge clk_200KHz or posedge reset) begin
        if (reset) begin
            scl_sync     <= 2'b11;
            sda_sync     <= 2'b11;
            scl_hist     <= 1'b1;
            sda_hist     <= 1'b1;
            state        <= IDLE;
            rx_sr        <= '0;
            tx_sr        <= '0;
            bit_cnt      <= '0;
            byte_sel     <= 1'b0;
            tx_shadow    <= '0;
            sda_pull_low <= 1'b0;
            busy         <= 1'b0;
            address_hit  <= 1'b0;
            read_done    <= 1'b0;
        end else begin
            scl_sync     <= {scl_sync[0], scl_in};
            sda_sync     <= {sda_sync[0], sda_in};
            scl_hist     <= scl;
            sda_hist     <= sda;
            state        <= state_nxt;
            rx_sr        <= rx_sr_nxt;
            tx_sr        <= tx_sr_nxt;
            bit_cnt      <= bit_cnt_nxt;
            byte_sel     <= byte_sel_nxt;
            tx_shadow    <= tx_shadow_nxt;
            sda_pull_low <= pull_nxt;
            busy         <= busy_nxt;
            address_hit  <= hit_nxt;
            read_done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rx_sr_nxt     = rx_sr;
        tx_sr_nxt     = tx_sr;
        bit_cnt_nxt   = bit_cnt;
        byte_sel_nxt  = byte_sel;
        tx_shadow_nxt = tx_shadow;
        pull_nxt      = sda_pull_low;
        busy_nxt      = busy;
        hit_nxt       = 1'b0;
        done_nxt      = 1'b0;
        if (stop) begin
            state_nxt = IDLE;
            pull_nxt  = 1'b0;
            busy_nxt  = 1'b0;
        end else if (start) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = '0;
            pull_nxt    = 1'b0;
            busy_nxt    = 1'b1;
        end else begin
            case (state)
                IDLE: pull_nxt = 1'b0;
                ADDR: begin
                    if (scl_rise) begin
                        rx_sr_nxt   = {rx_sr[6:0], sda};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (rx_sr == {DEVICE_ADDRESS, 1'b1}) begin
                            state_nxt     = ADDR_ACK;
                            pull_nxt      = 1'b1;
                            tx_shadow_nxt = temperature_word;
                            hit_nxt       = 1'b1;
                        end else begin
                            state_nxt = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        state_nxt    = TX_BYTE;
                        byte_sel_nxt = 1'b0;
                        pull_nxt     = ~tx_shadow[15];
                        tx_sr_nxt    = {tx_shadow[14:8], 1'b0};
                        bit_cnt_nxt  = 4'd1;
                    end
                end
                TX_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_nxt = MASTER_ACK;
                            pull_nxt  = 1'b0;
                        end else begin
                            pull_nxt    = ~tx_sr[7];
                            tx_sr_nxt   = {tx_sr[6:0], 1'b0};
                            bit_cnt_nxt = bit_cnt + 4'd1;
                        end
                    end
                end
                MASTER_ACK: begin
                    // A fall here always follows an ACKed rise; a NACK leaves the state
                    if (scl_rise) begin
                        if (sda) begin
                            state_nxt = WAIT_STOP;
                            done_nxt  = 1'b1;
                        end else begin
                            byte_sel_nxt = ~byte_sel;
                        end
                    end else if (scl_fall) begin
                        state_nxt   = TX_BYTE;
                        pull_nxt    = ~cur_byte[7];
                        tx_sr_nxt   = {cur_byte[6:0], 1'b0};
                        bit_cnt_nxt = 4'd1;
                    end
                end
                WAIT_STOP: pull_nxt = 1'b0;
                default: begin
                    state_nxt = IDLE;
                    pull_nxt  = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_temperature_sensor_responder.sv
// tb_temperature_sensor_responder: directed I2C master transactions against the responder.
module tb_temperature_sensor_responder;
    logic clk_200KHz = 1'b0;
    logic reset, scl_m, sda_m;
    logic [15:0] temperature_word;
    logic sda_pull_low, busy, address_hit, read_done, sda_bus;
    int total = 0, bad = 0;
    int hits = 0, dones = 0, pulls = 0;
    int h0, d0, p0;
    logic a, b;
    logic [7:0] d;

    assign sda_bus = sda_m & ~sda_pull_low;

    temperature_sensor_responder dut (
        .clk_200KHz(clk_200KHz),
        .reset(reset),
        .scl_in(scl_m),
        .sda_in(sda_bus),
        .temperature_word(temperature_word),
        .sda_pull_low(sda_pull_low),
        .busy(busy),
        .address_hit(address_hit),
        .read_done(read_done)
    );

    always #5 clk_200KHz = ~clk_200KHz;

    always @(negedge clk_200KHz) begin
        if (address_hit) hits <= hits + 1;
        if (read_done) dones <= dones + 1;
        if (sda_pull_low) pulls <= pulls + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic i2c_start();
        if (!scl_m) begin
            #50 sda_m = 1'b1;
            #50 scl_m = 1'b1;
        end
        #100 sda_m = 1'b0;
        #100 scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        #50 sda_m = 1'b0;
        #50 scl_m = 1'b1;
        #100 sda_m = 1'b1;
        #100;
    endtask

    task automatic clk_bit(input logic v, output logic r);
        #50 sda_m = v;
        #50 scl_m = 1'b1;
        #50 r = sda_bus;
        #50 scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clk_bit(v[i], r);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] v);
        logic r;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, r);
            v = {v[6:0], r};
        end
        clk_bit(nack, r);
    endtask

    initial begin
        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        temperature_word = 16'h1A80;
        #25;
        check("rst_pull", sda_pull_low, 0);
        check("rst_busy", busy, 0);
        check("rst_hit", address_hit, 0);
        check("rst_done", read_done, 0);
        #25 reset = 1'b0;
        #200;
        h0 = hits; d0 = dones;
        i2c_start();
        send_byte(8'h97, a);
        check("t1_addr_ack", a, 0);
        check("t1_busy", busy, 1);
        read_byte(1'b0, d);
        check("t1_msb", d, 8'h1A);
        read_byte(1'b1, d);
        check("t1_lsb", d, 8'h80);
        i2c_stop();
        check("t1_busy_end", busy, 0);
        check("t1_hits", hits - h0, 1);
        check("t1_dones", dones - d0, 1);
        h0 = hits; d0 = dones; p0 = pulls;
        i2c_start();
        send_byte(8'h95, a);
        check("t2_no_ack", a, 1);
        check("t2_busy", busy, 1);
        i2c_stop();
        check("t2_busy_end", busy, 0);
        check("t2_no_pull", pulls - p0, 0);
        check("t2_hits", hits - h0, 0);
        check("t2_dones", dones - d0, 0);
        h0 = hits; p0 = pulls;
        i2c_start();
        send_byte(8'h96, a);
        check("t3_no_ack", a, 1);
        read_byte(1'b1, d);
        check("t3_bus_free", d, 8'hFF);
        check("t3_busy", busy, 1);
        i2c_stop();
        check("t3_busy_end", busy, 0);
        check("t3_no_pull", pulls - p0, 0);
        check("t3_hits", hits - h0, 0);
        d0 = dones;
        i2c_start();
        send_byte(8'h97, a);
        check("t4_addr_ack", a, 0);
        read_byte(1'b0, d);
        check("t4_b0", d, 8'h1A);
        read_byte(1'b0, d);
        check("t4_b1", d, 8'h80);
        check("t4_no_done_yet", dones - d0, 0);
        read_byte(1'b1, d);
        check("t4_b2", d, 8'h1A);
        check("t4_done", dones - d0, 1);
        i2c_stop();
        i2c_start();
        send_byte(8'h97, a);
        check("t5_addr_ack", a, 0);
        temperature_word = 16'h7FF0;
        read_byte(1'b0, d);
        check("t5_msb", d, 8'h1A);
        read_byte(1'b1, d);
        check("t5_lsb", d, 8'h80);
        i2c_stop();
        temperature_word = 16'h0080;
        i2c_start();
        send_byte(8'h97, a);
        check("t6_addr_ack", a, 0);
        for (int i = 0; i < 3; i++) clk_bit(1'b1, b);
        #50;
        check("t6_driving", sda_pull_low, 1);
        reset = 1'b1;
        #1;
        check("t6_rst_pull", sda_pull_low, 0);
        check("t6_rst_busy", busy, 0);
        #49 reset = 1'b0;
        temperature_word = 16'h1A80;
        i2c_start();
        send_byte(8'h97, a);
        check("t6_re_ack", a, 0);
        read_byte(1'b0, d);
        check("t6_msb", d, 8'h1A);
        read_byte(1'b1, d);
        check("t6_lsb", d, 8'h80);
        i2c_stop();
        h0 = hits;
        i2c_start();
        send_byte(8'h97, a);
        check("t7_addr_ack", a, 0);
        for (int i = 0; i < 3; i++) clk_bit(1'b1, b);
        temperature_word = 16'h7FF0;
        i2c_start();
        check("t7_busy", busy, 1);
        send_byte(8'h97, a);
        check("t7_re_ack", a, 0);
        read_byte(1'b0, d);
        check("t7_msb", d, 8'h7F);
        read_byte(1'b1, d);
        check("t7_lsb", d, 8'hF0);
        i2c_stop();
        check("t7_hits", hits - h0, 2);
        check("t7_busy_end", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
